fp_result_checker: RTL and testbench

- Hardware response checker for the FP adder/subtractor test-vector stream: consumer end of the vector protocol whose producer drives x, y, sub and expected result.
- Accepts one vector per beat over valid/ready together with the DUT's actual result.
- Applies NaN-aware compare, keeps pass/fail counters, captures the first failing vector and reports a final verdict.
- Sits beside the FP unit in on-chip self-test and FPGA bring-up.

---
 rtl/fp_result_checker.sv | 157 +++++++++++++++
 tb/tb_fp_result_checker.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_result_checker.sv
// Response checker for an FP add/sub test-vector stream. Accepts one vector per
// valid/ready beat together with the unit's actual result, compares NaN-aware,
// keeps saturating pass/fail counters, captures the first failing vector and
// reports a final verdict.
module fp_result_checker #(
  parameter int unsigned BITS          = 32,
  parameter int unsigned MANTISSA_BITS = 23,
  parameter int unsigned EXPONENT_BITS = 8,
  parameter int unsigned COUNT_BITS    = 32,
  parameter bit          STOP_ON_FAIL  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BITS-1:0]       x,
  input  logic [BITS-1:0]       y,
  input  logic                  sub,
  input  logic [BITS-1:0]       expected,
  input  logic [BITS-1:0]       actual,
  input  logic                  last,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [COUNT_BITS-1:0] vec_count,
  output logic [COUNT_BITS-1:0] fail_count,
  output logic                  fail_valid,
  output logic [COUNT_BITS-1:0] fail_index,
  output logic [BITS-1:0]       fail_x,
  output logic [BITS-1:0]       fail_y,
  output logic                  fail_sub,
  output logic [BITS-1:0]       fail_expected,
  output logic [BITS-1:0]       fail_actual
);

  typedef enum logic [1:0] {StIdle, StRun, StHalt, StDone} state_e;

  localparam logic [COUNT_BITS-1:0] CountMax = {COUNT_BITS{1'b1}};

  state_e                  state_q, state_d;
  logic [COUNT_BITS-1:0]   vec_count_q, vec_count_d;
  logic [COUNT_BITS-1:0]   fail_count_q, fail_count_d;
  logic                    fail_valid_q, fail_valid_d;
  logic [COUNT_BITS-1:0]   fail_index_q, fail_index_d;
  logic [BITS-1:0]         fail_x_q, fail_x_d;
  logic [BITS-1:0]         fail_y_q, fail_y_d;
  logic                    fail_sub_q, fail_sub_d;
  logic [BITS-1:0]         fail_expected_q, fail_expected_d;
  logic [BITS-1:0]         fail_actual_q, fail_actual_d;

  logic accept;
  logic exp_is_nan;
  logic act_is_nan;
  logic mismatch;

  // Handshake: start has priority, so a beat presented alongside start is dropped.
  assign in_ready = (state_q == StRun) && !start;
  assign accept   = in_valid && in_ready;

  // NaN-aware compare: any NaN matches any NaN, everything else is bit-exact.
  assign exp_is_nan = (&expected[MANTISSA_BITS +: EXPONENT_BITS]) &&
                      (|expected[MANTISSA_BITS-1:0]);
  assign act_is_nan = (&actual[MANTISSA_BITS +: EXPONENT_BITS]) &&
                      (|actual[MANTISSA_BITS-1:0]);
  assign mismatch   = exp_is_nan ? !act_is_nan : (actual != expected);

  // Next-state: start clears everything and (re)enters RUN; otherwise only an
  // accepted beat (which implies RUN) moves counters, capture or state.
  always_comb begin
    state_d         = state_q;
    vec_count_d     = vec_count_q;
    fail_count_d    = fail_count_q;
    fail_valid_d    = fail_valid_q;
    fail_index_d    = fail_index_q;
    fail_x_d        = fail_x_q;
    fail_y_d        = fail_y_q;
    fail_sub_d      = fail_sub_q;
    fail_expected_d = fail_expected_q;
    fail_actual_d   = fail_actual_q;

    if (start) begin
      state_d         = StRun;
      vec_count_d     = '0;
      fail_count_d    = '0;
      fail_valid_d    = 1'b0;
      fail_index_d    = '0;
      fail_x_d        = '0;
      fail_y_d        = '0;
      fail_sub_d      = 1'b0;
      fail_expected_d = '0;
      fail_actual_d   = '0;
    end else if (accept) begin
      if (vec_count_q != CountMax) vec_count_d = vec_count_q + COUNT_BITS'(1);
      if (mismatch) begin
        if (fail_count_q != CountMax) fail_count_d = fail_count_q + COUNT_BITS'(1);
        // Only the first failure is kept; the index is the pre-increment count.
        if (!fail_valid_q) begin
          fail_valid_d    = 1'b1;
          fail_index_d    = vec_count_q;
          fail_x_d        = x;
          fail_y_d        = y;
          fail_sub_d      = sub;
          fail_expected_d = expected;
          fail_actual_d   = actual;
        end
      end
      // A halting mismatch wins over last.
      if (mismatch && STOP_ON_FAIL) begin
        state_d = StHalt;
      end else if (last) begin
        state_d = StDone;
      end
    end
  end

  // State and result registers, asynchronously cleared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= StIdle;
      vec_count_q     <= '0;
      fail_count_q    <= '0;
      fail_valid_q    <= 1'b0;
      fail_index_q    <= '0;
      fail_x_q        <= '0;
      fail_y_q        <= '0;
      fail_sub_q      <= 1'b0;
      fail_expected_q <= '0;
      fail_actual_q   <= '0;
    end else begin
      state_q         <= state_d;
      vec_count_q     <= vec_count_d;
      fail_count_q    <= fail_count_d;
      fail_valid_q    <= fail_valid_d;
      fail_index_q    <= fail_index_d;
      fail_x_q        <= fail_x_d;
      fail_y_q        <= fail_y_d;
      fail_sub_q      <= fail_sub_d;
      fail_expected_q <= fail_expected_d;
      fail_actual_q   <= fail_actual_d;
    end
  end

  assign busy          = (state_q == StRun);
  assign done          = (state_q == StHalt) || (state_q == StDone);
  assign pass          = done && (fail_count_q == '0);
  assign vec_count     = vec_count_q;
  assign fail_count    = fail_count_q;
  assign fail_valid    = fail_valid_q;
  assign fail_index    = fail_index_q;
  assign fail_x        = fail_x_q;
  assign fail_y        = fail_y_q;
  assign fail_sub      = fail_sub_q;
  assign fail_expected = fail_expected_q;
  assign fail_actual   = fail_actual_q;

endmodule

// File: tb/tb_fp_result_checker.sv
// Bench for fp_result_checker: three instances (halting, run-to-end, and a
// 2-bit-counter run-to-end copy for saturation) share one stimulus stream and
// are each compared every cycle against a small behavioural model.
module tb_fp_result_checker;

  localparam int NI = 3;
  localparam int MIdle = 0, MRun = 1, MHalt = 2, MDone = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0, in_valid = 1'b0, sub = 1'b0, last = 1'b0;
  logic [31:0] x = '0, y = '0, expected = '0, actual = '0;

  logic        a_ready, a_busy, a_done, a_pass, a_fv, a_fs;
  logic [31:0] a_vec, a_fc, a_fi, a_fx, a_fy, a_fe, a_fa;
  logic        b_ready, b_busy, b_done, b_pass, b_fv, b_fs;
  logic [31:0] b_vec, b_fc, b_fi, b_fx, b_fy, b_fe, b_fa;
  logic        c_ready, c_busy, c_done, c_pass, c_fv, c_fs;
  logic [1:0]  c_vec, c_fc, c_fi;
  logic [31:0] c_fx, c_fy, c_fe, c_fa;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state per instance.
  int          m_st[NI];
  logic [31:0] m_vc[NI], m_fc[NI], m_fi[NI], m_fx[NI], m_fy[NI], m_fe[NI], m_fa[NI];
  logic        m_fv[NI], m_fs[NI];
  logic [31:0] m_max[NI]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd3};
  bit          m_stop[NI] = '{1'b1, 1'b0, 1'b0};

  always #5 clk = ~clk;

  fp_result_checker #(.STOP_ON_FAIL(1'b1)) dut_a (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(a_ready),
    .x(x), .y(y), .sub(sub), .expected(expected), .actual(actual), .last(last),
    .busy(a_busy), .done(a_done), .pass(a_pass), .vec_count(a_vec), .fail_count(a_fc),
    .fail_valid(a_fv), .fail_index(a_fi), .fail_x(a_fx), .fail_y(a_fy), .fail_sub(a_fs),
    .fail_expected(a_fe), .fail_actual(a_fa)
  );

  fp_result_checker #(.STOP_ON_FAIL(1'b0)) dut_b (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(b_ready),
    .x(x), .y(y), .sub(sub), .expected(expected), .actual(actual), .last(last),
    .busy(b_busy), .done(b_done), .pass(b_pass), .vec_count(b_vec), .fail_count(b_fc),
    .fail_valid(b_fv), .fail_index(b_fi), .fail_x(b_fx), .fail_y(b_fy), .fail_sub(b_fs),
    .fail_expected(b_fe), .fail_actual(b_fa)
  );

  fp_result_checker #(.COUNT_BITS(2), .STOP_ON_FAIL(1'b0)) dut_c (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(c_ready),
    .x(x), .y(y), .sub(sub), .expected(expected), .actual(actual), .last(last),
    .busy(c_busy), .done(c_done), .pass(c_pass), .vec_count(c_vec), .fail_count(c_fc),
    .fail_valid(c_fv), .fail_index(c_fi), .fail_x(c_fx), .fail_y(c_fy), .fail_sub(c_fs),
    .fail_expected(c_fe), .fail_actual(c_fa)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit is_nan(input logic [31:0] v);
    return (v[30:23] == 8'hFF) && (v[22:0] != 23'd0);
  endfunction

  function automatic bit differs(input logic [31:0] e, input logic [31:0] a);
    if (is_nan(e)) return !is_nan(a);
    return a !== e;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NI; k++) begin
      m_st[k] = MIdle; m_vc[k] = '0; m_fc[k] = '0; m_fv[k] = 1'b0; m_fi[k] = '0;
      m_fx[k] = '0; m_fy[k] = '0; m_fs[k] = 1'b0; m_fe[k] = '0; m_fa[k] = '0;
    end
  endtask

  task automatic model_step(input int k);
    if (start) begin
      m_st[k] = MRun; m_vc[k] = '0; m_fc[k] = '0; m_fv[k] = 1'b0; m_fi[k] = '0;
      m_fx[k] = '0; m_fy[k] = '0; m_fs[k] = 1'b0; m_fe[k] = '0; m_fa[k] = '0;
    end else if (m_st[k] == MRun && in_valid) begin
      bit bad = differs(expected, actual);
      if (bad && !m_fv[k]) begin
        m_fv[k] = 1'b1; m_fi[k] = m_vc[k];
        m_fx[k] = x; m_fy[k] = y; m_fs[k] = sub; m_fe[k] = expected; m_fa[k] = actual;
      end
      if (m_vc[k] != m_max[k]) m_vc[k] = m_vc[k] + 1;
      if (bad && m_fc[k] != m_max[k]) m_fc[k] = m_fc[k] + 1;
      if (bad && m_stop[k]) m_st[k] = MHalt;
      else if (last) m_st[k] = MDone;
    end
  endtask

  task automatic compare_inst(input int k, input logic busy, input logic done,
                              input logic pass, input logic fv, input logic fs,
                              input logic [31:0] vec, input logic [31:0] fc,
                              input logic [31:0] fi, input logic [31:0] fx,
                              input logic [31:0] fy, input logic [31:0] fe,
                              input logic [31:0] fa);
    bit m_done = (m_st[k] == MHalt) || (m_st[k] == MDone);
    check($sformatf("busy[%0d]", k), {31'd0, busy}, {31'd0, m_st[k] == MRun});
    check($sformatf("done[%0d]", k), {31'd0, done}, {31'd0, m_done});
    check($sformatf("pass[%0d]", k), {31'd0, pass}, {31'd0, m_done && m_fc[k] == 0});
    check($sformatf("vec_count[%0d]", k), vec, m_vc[k]);
    check($sformatf("fail_count[%0d]", k), fc, m_fc[k]);
    check($sformatf("fail_valid[%0d]", k), {31'd0, fv}, {31'd0, m_fv[k]});
    check($sformatf("fail_index[%0d]", k), fi, m_fi[k]);
    check($sformatf("fail_x[%0d]", k), fx, m_fx[k]);
    check($sformatf("fail_y[%0d]", k), fy, m_fy[k]);
    check($sformatf("fail_sub[%0d]", k), {31'd0, fs}, {31'd0, m_fs[k]});
    check($sformatf("fail_expected[%0d]", k), fe, m_fe[k]);
    check($sformatf("fail_actual[%0d]", k), fa, m_fa[k]);
  endtask

  task automatic compare_all();
    compare_inst(0, a_busy, a_done, a_pass, a_fv, a_fs, a_vec, a_fc, a_fi,
                 a_fx, a_fy, a_fe, a_fa);
    compare_inst(1, b_busy, b_done, b_pass, b_fv, b_fs, b_vec, b_fc, b_fi,
                 b_fx, b_fy, b_fe, b_fa);
    compare_inst(2, c_busy, c_done, c_pass, c_fv, c_fs, {30'd0, c_vec}, {30'd0, c_fc},
                 {30'd0, c_fi}, c_fx, c_fy, c_fe, c_fa);
  endtask

  task automatic check_ready();
    check("in_ready[0]", {31'd0, a_ready}, {31'd0, m_st[0] == MRun && !start && !rst});
    check("in_ready[1]", {31'd0, b_ready}, {31'd0, m_st[1] == MRun && !start && !rst});
    check("in_ready[2]", {31'd0, c_ready}, {31'd0, m_st[2] == MRun && !start && !rst});
  endtask

  // One clock: called at a falling edge, drives inputs, checks ready before the
  // rising edge, steps the model, checks all outputs just after the edge.
  task automatic cycle(input bit st, input bit v, input logic [31:0] xx,
                       input logic [31:0] yy, input bit s, input logic [31:0] e,
                       input logic [31:0] a, input bit l);
    start = st; in_valid = v; x = xx; y = yy; sub = s; expected = e; actual = a; last = l;
    #1;
    check_ready();
    for (int k = 0; k < NI; k++) model_step(k);
    @(posedge clk);
    #1;
    compare_all();
    @(negedge clk);
  endtask

  task automatic pulse_start();
    cycle(1'b1, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic beat(input logic [31:0] xx, input logic [31:0] yy, input bit s,
                      input logic [31:0] e, input logic [31:0] a, input bit l);
    cycle(1'b0, 1'b1, xx, yy, s, e, a, l);
  endtask

  // Reset asserted mid-cycle, away from any clock edge.
  task automatic async_reset();
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    compare_all();
    check_ready();
    @(negedge clk);
    rst = 1'b0; start = 1'b0; in_valid = 1'b0;
  endtask

  function automatic logic [31:0] rand_nan();
    logic [22:0] m = 23'($urandom);
    if (m == 23'd0) m = 23'd1;
    return {1'($urandom), 8'hFF, m};
  endfunction

  initial begin
    model_reset();
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    compare_all();
    check_ready();
    rst = 1'b0;
    @(negedge clk);

    // Reset while running with two vectors counted.
    pulse_start();
    beat(32'h1, 32'h2, 1'b0, 32'h3, 32'h3, 1'b0);
    beat(32'h4, 32'h5, 1'b0, 32'h6, 32'h6, 1'b0);
    check("t1_vec_before", a_vec, 32'd2);
    async_reset();
    check("t1_vec", a_vec, 32'd0);
    check("t1_ready", {31'd0, a_ready}, 32'd0);
    check("t1_done", {31'd0, a_done}, 32'd0);

    // Three matching beats.
    pulse_start();
    beat(32'h3F80_0000, 32'h3F80_0000, 1'b0, 32'h4000_0000, 32'h4000_0000, 1'b0);
    beat(32'h4000_0000, 32'h4000_0000, 1'b0, 32'h4080_0000, 32'h4080_0000, 1'b0);
    beat(32'h3F80_0000, 32'h3F80_0000, 1'b1, 32'h0000_0000, 32'h0000_0000, 1'b1);
    check("t2_done", {31'd0, a_done}, 32'd1);
    check("t2_pass", {31'd0, a_pass}, 32'd1);
    check("t2_vec", a_vec, 32'd3);
    check("t2_fail_count", a_fc, 32'd0);
    check("t2_fail_valid", {31'd0, a_fv}, 32'd0);

    // NaN rule: any NaN matches, infinity does not.
    pulse_start();
    beat(32'h7F80_0000, 32'hFF80_0000, 1'b0, 32'h7FC0_0000, 32'hFFA0_0001, 1'b0);
    check("t3_nan_match", b_fc, 32'd0);
    beat(32'h7F80_0000, 32'h7F80_0000, 1'b1, 32'h7FC0_0000, 32'h7F80_0000, 1'b1);
    check("t3_nan_vs_inf", b_fc, 32'd1);
    check("t3_halt_count", a_fc, 32'd1);

    // Halt at first failure (instance 0); five beats offered.
    pulse_start();
    for (int i = 0; i < 5; i++)
      beat(32'h100 + 32'(i), 32'h200 + 32'(i), 1'(i), 32'h0, (i == 1) ? 32'h1 : 32'h0,
           i == 4);
    check("t4_vec", a_vec, 32'd2);
    check("t4_fail_index", a_fi, 32'd1);
    check("t4_fail_x", a_fx, 32'h101);
    check("t4_fail_y", a_fy, 32'h201);
    check("t4_fail_sub", {31'd0, a_fs}, 32'd1);
    check("t4_fail_actual", a_fa, 32'h1);
    check("t4_pass", {31'd0, a_pass}, 32'd0);
    check("t4_ready", {31'd0, a_ready}, 32'd0);

    // Run to last with two failures (instances 1 and 2; 2 saturates vec_count at 3).
    pulse_start();
    for (int i = 0; i < 5; i++)
      beat(32'h300 + 32'(i), 32'h400 + 32'(i), 1'b0, 32'h3F80_0000,
           (i == 1 || i == 3) ? 32'hBF80_0000 : 32'h3F80_0000, i == 4);
    check("t5_done", {31'd0, b_done}, 32'd1);
    check("t5_vec", b_vec, 32'd5);
    check("t5_fail_count", b_fc, 32'd2);
    check("t5_fail_index", b_fi, 32'd1);
    check("t5_pass", {31'd0, b_pass}, 32'd0);
    check("t5_sat_vec", {30'd0, c_vec}, 32'd3);

    // start together with a valid beat while running.
    pulse_start();
    beat(32'h1, 32'h1, 1'b0, 32'h5, 32'h5, 1'b0);
    cycle(1'b1, 1'b1, 32'h1, 32'h1, 1'b0, 32'h5, 32'h6, 1'b0);
    check("t6_vec", b_vec, 32'd0);
    check("t6_busy", {31'd0, b_busy}, 32'd1);

    // Randomised traffic with occasional restarts and resets.
    for (int n = 0; n < 1500; n++) begin
      bit          st, v, l, s;
      logic [31:0] e, a, xx, yy;
      if ($urandom_range(0, 299) == 0) begin
        async_reset();
        continue;
      end
      st = (m_st[1] != MRun) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 59) == 0);
      v  = $urandom_range(0, 3) != 0;
      l  = $urandom_range(0, 11) == 0;
      s  = 1'($urandom);
      xx = $urandom;
      yy = $urandom;
      case ($urandom_range(0, 5))
        0:       e = rand_nan();
        1:       e = {1'($urandom), 8'hFF, 23'd0};
        2:       e = {1'($urandom), 31'd0};
        default: e = $urandom;
      endcase
      case ($urandom_range(0, 13))
        0:       a = rand_nan();
        1:       a = e ^ (32'd1 << $urandom_range(0, 31));
        2:       a = $urandom;
        3:       a = {~e[31], e[30:0]};
        default: a = e;
      endcase
      cycle(st, v, xx, yy, s, e, a, l);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
